gs_ddram_bridge: RTL

Byte-wide bridge between the General Sound memory port of the `tsconf` core and the 64-bit DDR3 (DDRAM_*) interface of the emu top level. It provides the GS 2 MB sample/program RAM. It converts single-byte reads and writes on the `gs_mem_*` bus into Avalon-style 64-bit DDRAM transactions, and keeps a one-line (8-byte) read cache so sequential sample fetches avoid DDR latency. It drives `ready`, which the top inverts to GS_WAIT; masking of unused address space stays in the top level.

---
 rtl/gs_ddram_pkg.sv | 23 ++
 rtl/gs_line_cache.sv | 49 ++++
 rtl/gs_ddram_bridge.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/gs_ddram_pkg.sv
// gs_ddram_pkg: shared types and constants for the GS-to-DDRAM byte bridge.
//   state_t        - bridge FSM states
//   GS_DDRAM_BASE  - default DDRAM word address of GS byte 0
//   GS_TAG_W       - width of the cached line tag (GS address bits [20:3])
//   sel_byte()     - pick one byte lane out of a 64-bit word
package gs_ddram_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_REQ  = 2'd1,
      RD_WAIT = 2'd2,
      WR_REQ  = 2'd3
   } state_t;

   localparam logic [28:0] GS_DDRAM_BASE = 29'h0600000;
   localparam int          GS_TAG_W      = 18;

   function automatic logic [7:0] sel_byte(input logic [63:0] word,
                                           input logic [2:0]  ofs);
      return word[{ofs, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/gs_line_cache.sv
// gs_line_cache: single 8-byte read line for the GS DDRAM bridge.
// Present only when GS_DDRAM_CACHE_EN is defined.
// Ports:
//   clk_sys, reset          - system clock, synchronous active-high reset
//   lookup_addr [20:0]      - GS byte address being looked up / written
//   hit, hit_byte [7:0]     - line valid and tag matches; byte at lookup_addr[2:0]
//   wr_en, wr_data [7:0]    - write-through update of the byte at lookup_addr
//   fill_en, fill_addr, fill_data - load a complete line returned from DDRAM
module gs_line_cache
   import gs_ddram_pkg::*;
(
   input  logic        clk_sys,
   input  logic        reset,
   input  logic [20:0] lookup_addr,
   output logic        hit,
   output logic [7:0]  hit_byte,
   input  logic        wr_en,
   input  logic [7:0]  wr_data,
   input  logic        fill_en,
   input  logic [20:0] fill_addr,
   input  logic [63:0] fill_data
);

   logic [63:0]         line;
   logic [GS_TAG_W-1:0] tag;
   logic                valid;

   assign hit      = valid && (tag == lookup_addr[20:3]);
   assign hit_byte = sel_byte(line, lookup_addr[2:0]);

   // NOTE: the line and tag are only 82 flops, so they are cleared with valid
   // for deterministic reset values; a real RAM array would reset only valid.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         line  <= '0;
         tag   <= '0;
         valid <= 1'b0;
      end else if (fill_en) begin
         // NOTE: non-blocking assignments keep every flop update in this
         // block reading the pre-edge values, whatever the statement order.
         line  <= fill_data;
         tag   <= fill_addr[20:3];
         valid <= 1'b1;
      end else if (wr_en) begin
         line[{lookup_addr[2:0], 3'b000} +: 8] <= wr_data;
      end
   end

endmodule

// File: rtl/gs_ddram_bridge.sv
// gs_ddram_bridge: byte-wide General Sound memory port to 64-bit DDRAM
// (Avalon-style) bridge providing the GS 2 MB RAM.
// Optional feature macro: GS_DDRAM_CACHE_EN (one-line 8-byte read cache).
// Ports:
//   clk_sys, reset            - system clock, synchronous active-high reset
//   addr [20:0], din [7:0]    - GS byte address and write data
//   rd, we                    - level requests; a rising edge starts an access
//   dout [7:0], ready         - read data; 1 = idle / last access done
//   DDRAM_BUSY                - waitrequest
//   DDRAM_BURSTCNT            - constant 1
//   DDRAM_ADDR/DIN/BE/RD/WE   - registered command outputs
//   DDRAM_DOUT, DDRAM_DOUT_READY - read return beat
module gs_ddram_bridge
   import gs_ddram_pkg::*;
#(
   parameter logic [28:0] BASE = GS_DDRAM_BASE
)(
   input  logic        clk_sys,
   input  logic        reset,
   input  logic [20:0] addr,
   input  logic [7:0]  din,
   output logic [7:0]  dout,
   input  logic        rd,
   input  logic        we,
   output logic        ready,
   input  logic        DDRAM_BUSY,
   output logic [7:0]  DDRAM_BURSTCNT,
   output logic [28:0] DDRAM_ADDR,
   input  logic [63:0] DDRAM_DOUT,
   input  logic        DDRAM_DOUT_READY,
   output logic        DDRAM_RD,
   output logic [63:0] DDRAM_DIN,
   output logic [7:0]  DDRAM_BE,
   output logic        DDRAM_WE
);

   state_t      state, state_n;
   logic        rd_q, we_q;
   logic        rd_edge, we_edge;
   logic [20:0] addr_q;
   logic        drain, drain_n, drain_rst;
   logic        rd_cmd_n, we_cmd_n;
   logic        capture, fill, hit_read;
   logic        cache_hit;
   logic [7:0]  cache_byte;

   assign DDRAM_BURSTCNT = 8'd1;

   assign rd_edge = rd && !rd_q;
   assign we_edge = we && !we_q;

`ifdef GS_DDRAM_CACHE_EN
   gs_line_cache u_line_cache (
      .clk_sys     (clk_sys),
      .reset       (reset),
      .lookup_addr (addr),
      .hit         (cache_hit),
      .hit_byte    (cache_byte),
      .wr_en       ((state == IDLE) && we_edge),
      .wr_data     (din),
      .fill_en     (fill),
      .fill_addr   (addr_q),
      .fill_data   (DDRAM_DOUT)
   );
`else
   assign cache_hit  = 1'b0;
   assign cache_byte = 8'h00;
`endif

   // A read beat still owed by DDRAM when reset hits must be swallowed later:
   // either the command was accepted this very cycle, or we were waiting on it.
   assign drain_rst = (state == RD_WAIT && !DDRAM_DOUT_READY)
                   || (state == RD_REQ && DDRAM_RD && !DDRAM_BUSY)
                   || (drain && !DDRAM_DOUT_READY);

   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a variable unassigned, which would infer a latch.
      state_n  = state;
      capture  = 1'b0;
      fill     = 1'b0;
      hit_read = 1'b0;
      drain_n  = drain && !DDRAM_DOUT_READY;

      unique case (state)
         IDLE: begin
            if (we_edge) begin
               // A write wins over a simultaneous read edge; the read is dropped.
               state_n = WR_REQ;
               capture = 1'b1;
            end else if (rd_edge) begin
               if (cache_hit) begin
                  hit_read = 1'b1;
               end else begin
                  state_n = RD_REQ;
                  capture = 1'b1;
               end
            end
         end
         RD_REQ: begin
            // Only a command actually on the bus can be accepted; while
            // draining, DDRAM_RD is held low and we simply wait here.
            if (DDRAM_RD && !DDRAM_BUSY) state_n = RD_WAIT;
         end
         RD_WAIT: begin
            if (DDRAM_DOUT_READY) begin
               fill    = 1'b1;
               state_n = IDLE;
            end
         end
         WR_REQ: begin
            if (!DDRAM_BUSY) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase

      rd_cmd_n = (state_n == RD_REQ) && !drain_n;
      we_cmd_n = (state_n == WR_REQ);
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state      <= IDLE;
         rd_q       <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         DDRAM_ADDR <= '0;
         DDRAM_DIN  <= '0;
         DDRAM_BE   <= '0;
         DDRAM_RD   <= 1'b0;
         DDRAM_WE   <= 1'b0;
         ready      <= 1'b1;
         dout       <= 8'h00;
         drain      <= drain_rst;
      end else begin
         state    <= state_n;
         rd_q     <= rd;
         we_q     <= we;
         DDRAM_RD <= rd_cmd_n;
         DDRAM_WE <= we_cmd_n;
         ready    <= (state_n == IDLE);
         drain    <= drain_n;

         if (capture) begin
            addr_q     <= addr;
            DDRAM_ADDR <= BASE + 29'(addr[20:3]);
            DDRAM_BE   <= 8'b1 << addr[2:0];
            DDRAM_DIN  <= {8{din}};
         end

         // A stale beat during drain never reaches here: fill needs RD_WAIT.
         if (hit_read) dout <= cache_byte;
         else if (fill) dout <= sel_byte(DDRAM_DOUT, addr_q[2:0]);
      end
   end

endmodule
